// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit word memory between the core's
// instruction-fetch port (I) and load/store port (D). One transaction in
// flight at a time; read data is registered; sub-word stores become a
// read-modify-write because the memory has no byte enables.
//
// Latency : grant -> rvalid is 1 cycle (load/fetch/full or empty store),
//           2 cycles for a partial store.
// Backpressure: grants are combinational and only issued in IDLE; a
//           requester holds req/addr/data until it sees its gnt.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   i_req/i_addr/i_gnt          fetch request side
//   i_rvalid/i_rdata            fetch response (registered)
//   d_req/d_we/d_addr/d_be/d_wdata/d_gnt   load/store request side
//   d_rvalid/d_rdata            load/store response (d_rdata=0 after stores)
//   mem_address/mem_data_in/mem_we/mem_data_out   memory interface
module mem_arbiter #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned AW            = 14
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory interface
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // 1 = D port received the most recent grant, 0 = I port
  logic        r_last_d;

  logic        r_i_rvalid;
  logic [31:0] r_i_rdata;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;

  // Read-modify-write context captured in the grant cycle
  logic [31:0] r_rmw_addr;
  logic [31:0] r_rmw_wdata;
  logic [3:0]  r_rmw_be;
  logic [31:0] r_rmw_old;

  logic [31:0] w_i_addr_m;
  logic [31:0] w_d_addr_m;
  logic        w_idle;
  logic        w_pick_d;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_d_full;
  logic        w_d_none;
  logic        w_d_partial;
  logic [31:0] w_merged;
  logic        w_unused;

  // Only word-aligned addresses within the AW-bit window reach memory.
  assign w_i_addr_m = {{(32-AW){1'b0}}, i_addr[AW-1:2], 2'b00};
  assign w_d_addr_m = {{(32-AW){1'b0}}, d_addr[AW-1:2], 2'b00};
  assign w_unused   = ^{i_addr[31:AW], i_addr[1:0], d_addr[31:AW], d_addr[1:0]};

  assign w_d_full    = (d_be == 4'hF);
  assign w_d_none    = (d_be == 4'h0);
  assign w_d_partial = d_we && !w_d_full && !w_d_none;

  // Grants are withheld while reset is asserted so no requester believes a
  // transaction was accepted that the reset is about to discard.
  assign w_idle = (r_state == IDLE) && resetn;

  // D wins when alone, always under data priority, or in round-robin when
  // I was served last.
  assign w_pick_d = d_req && (!i_req || DATA_PRIORITY || !r_last_d);
  assign w_d_gnt  = w_idle && w_pick_d;
  assign w_i_gnt  = w_idle && i_req && !w_pick_d;

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;

  // Byte-lane merge of new store data over the word read in the grant cycle
  always_comb begin
    w_merged = r_rmw_old;
    for (int n = 0; n < 4; n++) begin
      if (r_rmw_be[n]) begin
        w_merged[8*n +: 8] = r_rmw_wdata[8*n +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and memory-side outputs
  always_comb begin
    w_next_state = r_state;
    mem_address  = 32'h0;
    mem_data_in  = 32'h0;
    mem_we       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_d_gnt) begin
          mem_address = w_d_addr_m;
          if (d_we && w_d_full) begin
            mem_we      = 1'b1;
            mem_data_in = d_wdata;
          end
          w_next_state = w_d_partial ? RMW_WR : RESP;
        end else if (w_i_gnt) begin
          mem_address  = w_i_addr_m;
          w_next_state = RESP;
        end
      end
      RMW_WR: begin
        mem_we       = 1'b1;
        mem_address  = r_rmw_addr;
        mem_data_in  = w_merged;
        w_next_state = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    // A reset landing on a write cycle must not corrupt memory.
    if (!resetn) begin
      mem_we = 1'b0;
    end
  end

  // Response, arbitration history and RMW context
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_i_rvalid  <= 1'b0;
      r_i_rdata   <= 32'h0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= 32'h0;
      r_last_d    <= 1'b0;
      r_rmw_addr  <= 32'h0;
      r_rmw_wdata <= 32'h0;
      r_rmw_be    <= 4'h0;
      r_rmw_old   <= 32'h0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;

      if (w_i_gnt) begin
        r_last_d   <= 1'b0;
        r_i_rdata  <= mem_data_out;
        r_i_rvalid <= 1'b1;
      end

      if (w_d_gnt) begin
        r_last_d <= 1'b1;
        if (!d_we) begin
          r_d_rdata  <= mem_data_out;
          r_d_rvalid <= 1'b1;
        end else if (w_d_partial) begin
          // Response deferred until the merged word is written back
          r_rmw_addr  <= w_d_addr_m;
          r_rmw_wdata <= d_wdata;
          r_rmw_be    <= d_be;
          r_rmw_old   <= mem_data_out;
        end else begin
          r_d_rdata  <= 32'h0;
          r_d_rvalid <= 1'b1;
        end
      end

      if (r_state == RMW_WR) begin
        r_d_rdata  <= 32'h0;
        r_d_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;

  // Instance under data priority, with a memory model
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_we;

  // Round-robin instance, memory read data tied to a constant
  logic        rr_i_req;
  logic        rr_i_gnt;
  logic        rr_i_rvalid;
  logic [31:0] rr_i_rdata;
  logic        rr_d_req;
  logic        rr_d_gnt;
  logic        rr_d_rvalid;
  logic [31:0] rr_d_rdata;
  logic [31:0] rr_mem_address;
  logic [31:0] rr_mem_data_in;
  logic [31:0] rr_mem_data_out;
  logic        rr_mem_we;

  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_dat;

  int checks;
  int errors;

  mem_arbiter #(.DATA_PRIORITY(1'b1), .AW(14)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_we(mem_we)
  );

  mem_arbiter #(.DATA_PRIORITY(1'b0), .AW(14)) dut_rr (
    .clk(clk), .resetn(resetn),
    .i_req(rr_i_req), .i_addr(32'h0000_0020), .i_gnt(rr_i_gnt),
    .i_rvalid(rr_i_rvalid), .i_rdata(rr_i_rdata),
    .d_req(rr_d_req), .d_we(1'b0), .d_addr(32'h0000_0040), .d_be(4'h0),
    .d_wdata(32'h0), .d_gnt(rr_d_gnt), .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata),
    .mem_address(rr_mem_address), .mem_data_in(rr_mem_data_in),
    .mem_data_out(rr_mem_data_out), .mem_we(rr_mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on posedge; preload port for setup
  assign mem_data_out    = mem[mem_address[13:2]];
  assign rr_mem_data_out = 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (mem_we) mem[mem_address[13:2]] <= mem_data_in;
    if (pl_en)  mem[pl_idx] <= pl_dat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, leaving all requests deasserted
  task automatic step();
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; rr_i_req = 1'b0; rr_d_req = 1'b0;
    pl_en = 1'b0;
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] dat);
    step();
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
  endtask

  logic [1:0] rr_exp [0:6];

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0;
    rr_i_req = 1'b0; rr_d_req = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b00; rr_exp[2] = 2'b01; rr_exp[3] = 2'b00;
    rr_exp[4] = 2'b10; rr_exp[5] = 2'b00; rr_exp[6] = 2'b01;

    // Preload memory while reset is held
    preload(12'd0, 32'h0000_0000);
    preload(12'd1, 32'h0050_0093);
    preload(12'd2, 32'h1122_3344);
    preload(12'd4, 32'h0000_0000);
    preload(12'd6, 32'hCAFE_F00D);

    // Reset state; a store request during reset is neither granted nor written
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_be = 4'hF; d_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);

    // Test 1: fetch from 0x4
    step();
    resetn = 1'b1;
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    chk("t1_i_gnt", {31'b0, i_gnt}, 32'd1);
    chk("t1_addr", mem_address, 32'h4);
    step();
    #1;
    chk("t1_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h0050_0093);
    chk("t1_resp_no_gnt", {31'b0, i_gnt}, 32'd0);
    step();
    #1;
    chk("t1_rvalid_drop", {31'b0, i_rvalid}, 32'd0);
    chk("t1_rdata_hold", i_rdata, 32'h0050_0093);

    // Test 2: simultaneous fetch and load under data priority; the fetch
    // address carries high and low garbage bits that must not reach memory
    step();
    i_req = 1'b1; i_addr = 32'hFFFF_0007;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1;
    chk("t2_gnt_pair_a", {30'b0, d_gnt, i_gnt}, 32'b10);
    chk("t2_addr_d", mem_address, 32'h8);
    step();
    i_req = 1'b1;
    #1;
    chk("t2_gnt_pair_b", {30'b0, d_gnt, i_gnt}, 32'b00);
    chk("t2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'h1122_3344);
    step();
    i_req = 1'b1;
    #1;
    chk("t2_gnt_pair_c", {30'b0, d_gnt, i_gnt}, 32'b01);
    chk("t2_addr_i_masked", mem_address, 32'h4);
    step();
    #1;
    chk("t2_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("t2_d_rvalid_idle", {31'b0, d_rvalid}, 32'd0);
    chk("t2_i_rdata", i_rdata, 32'h0050_0093);

    // Test 3: round-robin instance with both requests held
    for (int k = 0; k < 7; k++) begin
      step();
      rr_i_req = 1'b1; rr_d_req = 1'b1;
      #1;
      chk($sformatf("t3_rr_gnt_%0d", k), {30'b0, rr_d_gnt, rr_i_gnt}, {30'b0, rr_exp[k]});
    end
    step();
    #1;
    chk("t3_rr_i_rdata", rr_i_rdata, 32'h5A5A_5A5A);

    // Test 4: partial store, upper halfword of word 2
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hA; d_be = 4'b1100; d_wdata = 32'hAABB_0000;
    #1;
    chk("t4_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t4_we_grant", {31'b0, mem_we}, 32'd0);
    chk("t4_addr_grant", mem_address, 32'h8);
    step();
    #1;
    chk("t4_we_rmw", {31'b0, mem_we}, 32'd1);
    chk("t4_addr_rmw", mem_address, 32'h8);
    chk("t4_data_rmw", mem_data_in, 32'hAABB_3344);
    chk("t4_rvalid_early", {31'b0, d_rvalid}, 32'd0);
    step();
    #1;
    chk("t4_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("t4_d_rdata_zero", d_rdata, 32'h0);
    chk("t4_we_resp", {31'b0, mem_we}, 32'd0);
    chk("t4_mem2", mem[2], 32'hAABB_3344);

    // Test 5: full store, load back, then empty-strobe store
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t5_we_full", {31'b0, mem_we}, 32'd1);
    chk("t5_data_full", mem_data_in, 32'hDEAD_BEEF);
    chk("t5_addr_full", mem_address, 32'h10);
    step();
    #1;
    chk("t5_rvalid_full", {31'b0, d_rvalid}, 32'd1);
    chk("t5_mem4", mem[4], 32'hDEAD_BEEF);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    #1;
    chk("t5_ld_gnt", {31'b0, d_gnt}, 32'd1);
    step();
    #1;
    chk("t5_ld_rdata", d_rdata, 32'hDEAD_BEEF);
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_be = 4'h0; d_wdata = 32'h1234_5678;
    #1;
    chk("t5_nop_gnt", {31'b0, d_gnt}, 32'd1);
    chk("t5_nop_we", {31'b0, mem_we}, 32'd0);
    step();
    #1;
    chk("t5_nop_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("t5_nop_rdata", d_rdata, 32'h0);
    chk("t5_nop_mem4", mem[4], 32'hDEAD_BEEF);

    // Test 6: reset asserted during the RMW write cycle
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h18; d_be = 4'b0001; d_wdata = 32'h0000_00EE;
    #1;
    chk("t6_d_gnt", {31'b0, d_gnt}, 32'd1);
    step();
    resetn = 1'b0;
    #1;
    chk("t6_we_suppressed", {31'b0, mem_we}, 32'd0);
    step();
    resetn = 1'b1;
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    chk("t6_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("t6_mem6", mem[6], 32'hCAFE_F00D);
    chk("t6_idle_gnt", {31'b0, i_gnt}, 32'd1);
    step();
    #1;
    chk("t6_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("t6_d_rvalid_after", {31'b0, d_rvalid}, 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
